spi_dac_rx: RTL and testbench
=============================

// Module: spi_dac_rx
// PURPOSE
// - SPI slave receiver and decoder for 24-bit LTC2624-style DAC frames.
// - Frame format, MSB first: {cmd[3:0], addr[3:0], data[11:0], 4'h0}.
// - Maintains four channel input/output registers; used as a synthesizable DAC model for loopback against the DAC driver.
// - Also serves as a control port for external masters.
// - All SPI pins are oversampled in the clk domain; no logic is clocked by spi_sck.
// PARAMETERS
// - SYNC_STAGES  2   flops per input synchronizer (>=2)
// - DATA_W       12  DAC code width
// PORTS
// - clk          in   1            system clock
// - reset_n      in   1            asynchronous, active-low reset
// - spi_sck      in   1            SPI clock from master (idle low)
// - spi_sdi      in   1            SPI data from master
// - spi_cs_n     in   1            chip select, active low
// - spi_sdo      out  1            daisy-chain data out (SPI_RX_SDO_EN only; else tied 0)
// - frame_valid  out  1            1-clk pulse: a good frame was decoded
// - frame_err    out  1            1-clk pulse: CS rose with bit count != 24
// - frame_cmd    out  4            cmd of last good frame
// - frame_addr   out  4            addr of last good frame
// - dac_out      out  4*DATA_W     output regs; ch A = [11:0] ... ch D = [47:36]
// - pd           out  4            per-channel power-down flags
// BEHAVIOUR
// - Reset (async assert, sync deassert inside block): all outputs 0; input/output regs 0; bit count 0.
// - Sampling:
//   - sck, sdi and cs_n each pass through a SYNC_STAGES synchronizer, then an edge-detect flop.
//   - sck high and low must each last >=2 clk; faster sck is unsupported.
// - States:
//   - IDLE: cs_n synced high; count held 0.
//   - SHIFT: entered on cs_n falling. Each sck rising: sr <= {sr[22:0], sdi}; count saturates at 31.
//   - DECODE: entered on cs_n rising; lasts 1 clk, then IDLE.
// - DECODE outcome:
//   - count==24: decode the frame and pulse frame_valid.
//   - any other count: pulse frame_err; no state changes.
// - Commands (per addressed channel n; addr 0-3 = A-D, 4'hF = all; other addr is a good frame with no effect):
//   - 0000: in[n] <= data
//   - 0001: out[n] <= in[n]; pd[n] <= 0
//   - 0010: in[n] <= data; then all out <= in; pd <= 0
//   - 0011: in[n] <= data; out[n] <= data; pd[n] <= 0
//   - 0100: pd[n] <= 1
//   - 1111 and others: no-op
//   - The new in[n] is visible to the same-frame update (0010 writes then updates).
// - Latency: dac_out, pd, frame_cmd and frame_addr update on the same edge frame_valid asserts, SYNC_STAGES+1 clk after the cs_n rising pin edge.
// - The sck edge that coincides with the cs_n rising edge (same sync cycle) is ignored.
// - cs_n low with no sck, then high: count 0, so frame_err pulses.
// - cs_n fall during DECODE: the new frame is accepted and count restarts at 0.
// - Reset mid-frame: the partial frame is discarded with no err pulse.
// CONFIGURATION
// - SPI_RX_SDO_EN defined:
//   - spi_sdo = sr[23], registered. Updates on ssynced sck falling while cs_n is low.
//   - Echoes the bit shifted in 24 sck earlier, for daisy-chaining. Held at 0 when cs_n is high.
// - SPI_RX_SDO_EN undefined: spi_sdo is constant 0 and the echo logic is omitted.
// TESTING
// - Frame 0x3_0_ABC_0 (cmd 3, ch A), sck=clk/4 -> dac_out[11:0]=12'hABC, frame_valid x1, frame_err 0.
// - cmd 0 ch B 12'h123, then cmd 1 ch B -> dac_out[23:12] stays 0 after the first frame; becomes 12'h123 after the second.
// - cmd 0 ch C 12'h555, then cmd 2 addr F 12'h0FF -> all four channels = 12'h0FF.
// - 23-bit frame, then 25-bit frame -> frame_err pulses twice; dac_out unchanged.
// - cmd 4 ch D, then cmd 3 ch D 12'h800 -> pd=4'b1000, then pd=4'b0000 with dac_out[47:36]=12'h800.
// - reset_n low at bit 12 of a frame, then a clean cmd 3 ch A 12'h001 frame -> dac_out[11:0]=12'h001, no frame_err.
// - SPI_RX_SDO_EN: 48-sck frame -> spi_sdo reproduces the first 24 sdi bits, delayed 24 sck.

Source files
------------

// File: rtl/spi_dac_rx.sv
// rtl/spi_dac_rx.sv - oversampled SPI slave decoding 24-bit LTC2624-style DAC frames; SPI_RX_SDO_EN adds the daisy-chain echo on spi_sdo
module spi_dac_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_W      = 12
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  spi_sck,
  input  logic                  spi_sdi,
  input  logic                  spi_cs_n,
  output logic                  spi_sdo,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [3:0]            frame_cmd,
  output logic [3:0]            frame_addr,
  output logic [4*DATA_W-1:0]   dac_out,
  output logic [3:0]            pd
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DECODE} state_e;

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] sck_sync_q, sdi_sync_q, cs_sync_q;
  logic                   sck_s, sdi_s, cs_s;
  logic                   sck_prev_q, cs_prev_q;
  logic                   sck_rise, cs_rise, cs_fall;

  state_e                 state_q;
  logic [23:0]            sr_q;
  logic [4:0]             cnt_q;
  logic                   frame_valid_q, frame_err_q;
  logic [3:0]             frame_cmd_q, frame_addr_q;
  logic [3:0][DATA_W-1:0] in_q, out_q;
  logic [3:0]             pd_q;

  logic [3:0]             dec_cmd, dec_addr, ch_mask;
  logic [DATA_W-1:0]      dec_data;
  logic [3:0][DATA_W-1:0] in_d, out_d;
  logic [3:0]             pd_d;
  logic                   sr_pad_unused;

  // Reset asserts immediately but releases two clocks after reset_n rises
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  // Pin synchronizers plus one history flop for edge detection; cs_n idles high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sck_sync_q <= '0;
      sdi_sync_q <= '0;
      cs_sync_q  <= '1;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b1;
    end else begin
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      sdi_sync_q <= {sdi_sync_q[SYNC_STAGES-2:0], spi_sdi};
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_prev_q <= sck_s;
      cs_prev_q  <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign sdi_s    = sdi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  assign dec_cmd       = sr_q[23:20];
  assign dec_addr      = sr_q[19:16];
  assign dec_data      = sr_q[4 +: DATA_W];
  assign sr_pad_unused = ^sr_q[3:0];

  // Address to channel mask: 0-3 pick one channel, F picks all, others none
  always_comb begin
    ch_mask = 4'b0000;
    case (dec_addr)
      4'h0:    ch_mask = 4'b0001;
      4'h1:    ch_mask = 4'b0010;
      4'h2:    ch_mask = 4'b0100;
      4'h3:    ch_mask = 4'b1000;
      4'hF:    ch_mask = 4'b1111;
      default: ch_mask = 4'b0000;
    endcase
  end

  // Next register contents if the shifted frame were committed now
  always_comb begin
    in_d  = in_q;
    out_d = out_q;
    pd_d  = pd_q;
    for (int i = 0; i < 4; i++) begin
      if (ch_mask[i]) begin
        case (dec_cmd)
          4'h0: in_d[i] = dec_data;
          4'h1: begin out_d[i] = in_q[i]; pd_d[i] = 1'b0; end
          4'h2: in_d[i] = dec_data;
          4'h3: begin in_d[i] = dec_data; out_d[i] = dec_data; pd_d[i] = 1'b0; end
          4'h4: pd_d[i] = 1'b1;
          default: ;
        endcase
      end
    end
    // Write-then-update: the global transfer sees the freshly written input reg
    if (dec_cmd == 4'h2 && ch_mask != 4'b0000) begin
      out_d = in_d;
      pd_d  = 4'b0000;
    end
  end

  // Frame FSM: shift on sck rise, commit or flag the frame when cs_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      sr_q          <= '0;
      cnt_q         <= '0;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cmd_q   <= '0;
      frame_addr_q  <= '0;
      in_q          <= '0;
      out_q         <= '0;
      pd_q          <= '0;
    end else begin
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (cs_fall) begin
            state_q <= ST_SHIFT;
            sr_q    <= '0;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            state_q <= ST_DECODE;
            if (cnt_q == 5'd24) begin
              frame_valid_q <= 1'b1;
              frame_cmd_q   <= dec_cmd;
              frame_addr_q  <= dec_addr;
              in_q          <= in_d;
              out_q         <= out_d;
              pd_q          <= pd_d;
            end else begin
              frame_err_q <= 1'b1;
            end
          end else if (sck_rise) begin
            sr_q <= {sr_q[22:0], sdi_s};
            if (cnt_q != 5'd31) cnt_q <= cnt_q + 5'd1;
          end
        end
        ST_DECODE: begin
          cnt_q <= '0;
          if (cs_fall) begin
            state_q <= ST_SHIFT;
            sr_q    <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_cmd   = frame_cmd_q;
  assign frame_addr  = frame_addr_q;
  assign dac_out     = out_q;
  assign pd          = pd_q;

`ifdef SPI_RX_SDO_EN
  logic sck_fall;
  logic sdo_q;
  assign sck_fall = ~sck_s & sck_prev_q;

  // Echo the bit shifted in 24 sck earlier on each sck fall; quiet while deselected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        sdo_q <= 1'b0;
    else if (cs_s)     sdo_q <= 1'b0;
    else if (sck_fall) sdo_q <= sr_q[23];
  end
  assign spi_sdo = sdo_q;
`else
  assign spi_sdo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_dac_rx.sv
// tb/tb_spi_dac_rx.sv - scoreboard bench for spi_dac_rx with directed DAC frames
module tb_spi_dac_rx;

  logic        clk = 1'b0;
  logic        reset_n, spi_sck, spi_sdi, spi_cs_n;
  logic        spi_sdo, frame_valid, frame_err;
  logic [3:0]  frame_cmd, frame_addr, pd;
  logic [47:0] dac_out;

  typedef struct packed {
    logic        err;
    logic [47:0] dac;
    logic [3:0]  pd;
    logic [3:0]  cmd;
    logic [3:0]  addr;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  logic [47:0] sdo_cap;

  spi_dac_rx #(.SYNC_STAGES(2), .DATA_W(12)) dut (
    .clk(clk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_sdi(spi_sdi),
    .spi_cs_n(spi_cs_n), .spi_sdo(spi_sdo), .frame_valid(frame_valid),
    .frame_err(frame_err), .frame_cmd(frame_cmd), .frame_addr(frame_addr),
    .dac_out(dac_out), .pd(pd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic push_v(input logic [47:0] d, input logic [3:0] p, input logic [3:0] c, input logic [3:0] a);
    exp_t e;
    e = '{err: 1'b0, dac: d, pd: p, cmd: c, addr: a};
    exp_q.push_back(e);
  endtask

  task automatic push_e(input logic [47:0] d, input logic [3:0] p);
    exp_t e;
    e = '{err: 1'b1, dac: d, pd: p, cmd: 4'h0, addr: 4'h0};
    exp_q.push_back(e);
  endtask

  // sck = clk/4; sdo is captured at the end of each high phase into sdo_cap[i]
  task automatic xfer(input logic [47:0] w, input int n);
    sdo_cap  = '0;
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = n - 1; i >= 0; i--) begin
      spi_sdi = w[i];
      repeat (2) @(negedge clk);
      spi_sck = 1'b1;
      repeat (2) @(negedge clk);
      sdo_cap[i] = spi_sdo;
      spi_sck = 1'b0;
    end
    repeat (2) @(negedge clk);
    spi_cs_n = 1'b1;
    spi_sdi  = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Monitor: every frame_valid/frame_err pulse consumes one expected entry
  always @(negedge clk) begin
    if (reset_n && (frame_valid || frame_err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse valid=%0b err=%0b required=none", frame_valid, frame_err);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_err", {63'd0, frame_err}, {63'd0, e.err});
        chk("pulse_valid", {63'd0, frame_valid}, {63'd0, ~e.err});
        chk("dac_out", {16'd0, dac_out}, {16'd0, e.dac});
        chk("pd", {60'd0, pd}, {60'd0, e.pd});
        if (!e.err) begin
          chk("frame_cmd", {60'd0, frame_cmd}, {60'd0, e.cmd});
          chk("frame_addr", {60'd0, frame_addr}, {60'd0, e.addr});
        end
      end
    end
  end

  initial begin
    reset_n  = 1'b0;
    spi_sck  = 1'b0;
    spi_sdi  = 1'b0;
    spi_cs_n = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_dac_out", {16'd0, dac_out}, 64'd0);
    chk("rst_pd", {60'd0, pd}, 64'd0);
    chk("rst_flags", {62'd0, frame_valid, frame_err}, 64'd0);
    chk("rst_cmd_addr", {56'd0, frame_cmd, frame_addr}, 64'd0);
    chk("rst_sdo", {63'd0, spi_sdo}, 64'd0);

    push_v(48'h000_000_000_ABC, 4'h0, 4'h3, 4'h0);
    xfer(48'h30ABC0, 24);
`ifndef SPI_RX_SDO_EN
    chk("sdo_tied0", {16'd0, sdo_cap}, 64'd0);
`endif
    push_v(48'h000_000_000_ABC, 4'h0, 4'h0, 4'h1);
    xfer(48'h011230, 24);
    push_v(48'h000_000_123_ABC, 4'h0, 4'h1, 4'h1);
    xfer(48'h110000, 24);
    push_v(48'h000_000_123_ABC, 4'h0, 4'h0, 4'h2);
    xfer(48'h025550, 24);
    push_v(48'h0FF_0FF_0FF_0FF, 4'h0, 4'h2, 4'hF);
    xfer(48'h2F0FF0, 24);
    push_e(48'h0FF_0FF_0FF_0FF, 4'h0);
    xfer(48'h12345, 23);
    push_e(48'h0FF_0FF_0FF_0FF, 4'h0);
    xfer(48'h1ABCDEF, 25);
    push_v(48'h0FF_0FF_0FF_0FF, 4'h8, 4'h4, 4'h3);
    xfer(48'h430000, 24);
    push_v(48'h800_0FF_0FF_0FF, 4'h0, 4'h3, 4'h3);
    xfer(48'h338000, 24);
    push_v(48'h800_0FF_0FF_0FF, 4'h0, 4'h3, 4'h5);
    xfer(48'h35FFF0, 24);

    // cs_n low with no sck at all
    push_e(48'h800_0FF_0FF_0FF, 4'h0);
    spi_cs_n = 1'b0;
    repeat (6) @(negedge clk);
    spi_cs_n = 1'b1;
    repeat (8) @(negedge clk);

    // Reset after 12 bits of a frame: discarded silently
    spi_cs_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 23; i >= 12; i--) begin
      spi_sdi = logic'((48'h30FFF0 >> i) & 48'h1);
      repeat (2) @(negedge clk);
      spi_sck = 1'b1;
      repeat (2) @(negedge clk);
      spi_sck = 1'b0;
    end
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_dac_out", {16'd0, dac_out}, 64'd0);
    chk("midrst_pd", {60'd0, pd}, 64'd0);
    spi_cs_n = 1'b1;
    spi_sdi  = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    push_v(48'h000_000_000_001, 4'h0, 4'h3, 4'h0);
    xfer(48'h300010, 24);
    push_v(48'h000_000_000_001, 4'h0, 4'h0, 4'h0);
    xfer(48'h007AA0, 24);
    push_v(48'h000_000_000_7AA, 4'h0, 4'h1, 4'hF);
    xfer(48'h1F0000, 24);

`ifdef SPI_RX_SDO_EN
    push_e(48'h000_000_000_7AA, 4'h0);
    xfer(48'hA5C396_3C5A69, 48);
    chk("sdo_echo", {40'd0, sdo_cap[23:0]}, 64'hA5C396);
`endif

    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
